// File: rtl/updown_counter_nbit.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_nbit
// Brief    : Loadable synchronous up/down counter with terminal value MAX_VAL
//            and a registered boundary-crossing pulse. Wraps at the bounds by
//            default; define UPDOWN_COUNTER_SATURATE_EN to saturate instead.
// Revision : 1.0 - initial release
// ============================================================================
module updown_counter_nbit #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = 2**WIDTH - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             at_max,
   output logic             bound
);

   localparam logic [WIDTH:0]   c_max_ext = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH-1:0] c_max     = c_max_ext[WIDTH-1:0];

   logic [WIDTH-1:0] r_q;
   logic             r_bound;

   logic [WIDTH:0]   w_inc;
   logic [WIDTH:0]   w_dec;
   logic             w_at_top;
   logic             w_at_bot;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_q_next;
   logic             w_bound_next;

   // One extra bit so q+1 never aliases and q-1 exposes the borrow at zero.
   assign w_inc    = {1'b0, r_q} + 1'b1;
   assign w_dec    = {1'b0, r_q} - 1'b1;
   assign w_at_top = (w_inc > c_max_ext);
   assign w_at_bot = w_dec[WIDTH];

   assign w_load_clamped = ({1'b0, load_val} > c_max_ext) ? c_max : load_val;

   always_comb begin
      w_q_next     = r_q;
      w_bound_next = 1'b0;
      if (load) begin
         w_q_next = w_load_clamped;
      end else if (en) begin
         if (up) begin
            if (w_at_top) begin
               w_bound_next = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
               w_q_next     = c_max;
`else
               w_q_next     = '0;
`endif
            end else begin
               w_q_next = w_inc[WIDTH-1:0];
            end
         end else begin
            if (w_at_bot) begin
               w_bound_next = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
               w_q_next     = '0;
`else
               w_q_next     = c_max;
`endif
            end else begin
               w_q_next = w_dec[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q     <= '0;
         r_bound <= 1'b0;
      end else begin
         r_q     <= w_q_next;
         r_bound <= w_bound_next;
      end
   end

   assign q      = r_q;
   assign zero   = (r_q == '0);
   assign at_max = ({1'b0, r_q} == c_max_ext);
   assign bound  = r_bound;

endmodule
`default_nettype wire
